// File: rtl/propuestacero_axil_pkg.sv
// ----------------------------------------------------------------------------
// propuestacero_axil_pkg : shared state encoding and AXI4-Lite constants, rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package propuestacero_axil_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WR   = 3'd1,
      ST_WR_B = 3'd2,
      ST_RD_A = 3'd3,
      ST_RD_R = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   localparam logic [1:0] c_okay   = 2'b00;
   localparam logic [1:0] c_slverr = 2'b10;
   localparam logic [1:0] c_decerr = 2'b11;

   localparam logic [3:0] c_reg0 = 4'h0;
   localparam logic [3:0] c_reg1 = 4'h4;
   localparam logic [3:0] c_reg2 = 4'h8;
   localparam logic [3:0] c_reg3 = 4'hC;

endpackage

`default_nettype wire

// File: rtl/propuestacero_rr_arb.sv
// ----------------------------------------------------------------------------
// propuestacero_rr_arb : 2-way round-robin grant with 'last' pointer, rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module propuestacero_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_req,
   input  logic       i_upd,
   input  logic       i_upd_idx,
   output logic       o_gnt_vld,
   output logic       o_gnt_idx
);

   logic r_last;
   logic w_other;

   // Favour the requester that was not served last; fall back to 'last' itself.
   assign w_other   = ~r_last;
   assign o_gnt_vld = |i_req;
   assign o_gnt_idx = i_req[w_other] ? w_other : r_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= 1'b1;
      end else if (i_upd) begin
         r_last <= i_upd_idx;
      end
   end

endmodule

`default_nettype wire

// File: rtl/propuestacero_axil_arbiter.sv
// ----------------------------------------------------------------------------
// propuestacero_axil_arbiter : 2-port arbiter sequencing single AXI4-Lite accesses, rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module propuestacero_axil_arbiter
   import propuestacero_axil_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic [1:0]            req,
   input  logic [1:0]            we,
   input  logic [ADDR_W-1:0]     addr0,
   input  logic [ADDR_W-1:0]     addr1,
   input  logic [DATA_W-1:0]     wdata0,
   input  logic [DATA_W-1:0]     wdata1,
   output logic [1:0]            done,
   output logic [DATA_W-1:0]     rdata,
   output logic [1:0]            resp,
   output logic [ADDR_W-1:0]     M_AXI_AWADDR,
   output logic [2:0]            M_AXI_AWPROT,
   output logic                  M_AXI_AWVALID,
   input  logic                  M_AXI_AWREADY,
   output logic [DATA_W-1:0]     M_AXI_WDATA,
   output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
   output logic                  M_AXI_WVALID,
   input  logic                  M_AXI_WREADY,
   input  logic [1:0]            M_AXI_BRESP,
   input  logic                  M_AXI_BVALID,
   output logic                  M_AXI_BREADY,
   output logic [ADDR_W-1:0]     M_AXI_ARADDR,
   output logic [2:0]            M_AXI_ARPROT,
   output logic                  M_AXI_ARVALID,
   input  logic                  M_AXI_ARREADY,
   input  logic [DATA_W-1:0]     M_AXI_RDATA,
   input  logic [1:0]            M_AXI_RRESP,
   input  logic                  M_AXI_RVALID,
   output logic                  M_AXI_RREADY
);

   state_t              r_state;
   logic                r_gnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_awvalid;
   logic                r_wvalid;
   logic                r_bready;
   logic                r_arvalid;
   logic                r_rready;
   logic [1:0]          r_done;
   logic [1:0]          r_resp;
   logic [DATA_W-1:0]   r_rdata;

   logic w_gnt_vld;
   logic w_gnt_idx;
   logic w_upd;
   logic w_aw_fin;
   logic w_w_fin;

   assign w_upd = (r_state == ST_DONE);

   propuestacero_rr_arb u_arb (
      .clk       (ACLK),
      .rst       (ARESET),
      .i_req     (req),
      .i_upd     (w_upd),
      .i_upd_idx (r_gnt),
      .o_gnt_vld (w_gnt_vld),
      .o_gnt_idx (w_gnt_idx)
   );

   // A channel is finished once its VALID has dropped or is handshaking now.
   assign w_aw_fin = !r_awvalid || M_AXI_AWREADY;
   assign w_w_fin  = !r_wvalid  || M_AXI_WREADY;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state   <= ST_IDLE;
         r_gnt     <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_arvalid <= 1'b0;
         r_rready  <= 1'b0;
         r_done    <= 2'b00;
         r_resp    <= c_okay;
         r_rdata   <= '0;
      end else begin
         r_done <= 2'b00;
         case (r_state)
            ST_IDLE: begin
               if (w_gnt_vld) begin
                  r_gnt   <= w_gnt_idx;
                  r_addr  <= w_gnt_idx ? addr1  : addr0;
                  r_wdata <= w_gnt_idx ? wdata1 : wdata0;
                  if (we[w_gnt_idx]) begin
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_state   <= ST_WR;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= ST_RD_A;
                  end
               end
            end
            ST_WR: begin
               if (M_AXI_AWREADY) r_awvalid <= 1'b0;
               if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
               if (w_aw_fin && w_w_fin) begin
                  r_bready <= 1'b1;
                  r_state  <= ST_WR_B;
               end
            end
            ST_WR_B: begin
               if (M_AXI_BVALID) begin
                  r_bready      <= 1'b0;
                  r_resp        <= M_AXI_BRESP;
                  r_rdata       <= '0;
                  r_done[r_gnt] <= 1'b1;
                  r_state       <= ST_DONE;
               end
            end
            ST_RD_A: begin
               if (M_AXI_ARREADY) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= ST_RD_R;
               end
            end
            ST_RD_R: begin
               if (M_AXI_RVALID) begin
                  r_rready      <= 1'b0;
                  r_rdata       <= M_AXI_RDATA;
                  r_resp        <= M_AXI_RRESP;
                  r_done[r_gnt] <= 1'b1;
                  r_state       <= ST_DONE;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign done          = r_done;
   assign rdata         = r_rdata;
   assign resp          = r_resp;
   assign M_AXI_AWADDR  = r_addr;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = r_awvalid;
   assign M_AXI_WDATA   = r_wdata;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_WVALID  = r_wvalid;
   assign M_AXI_BREADY  = r_bready;
   assign M_AXI_ARADDR  = r_addr;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = r_arvalid;
   assign M_AXI_RREADY  = r_rready;

endmodule

`default_nettype wire

// File: tb/tb_propuestacero_axil_arbiter.sv
// ----------------------------------------------------------------------------
// tb_propuestacero_axil_arbiter : scoreboard bench with AXI4-Lite slave model, rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_propuestacero_axil_arbiter;
   import propuestacero_axil_pkg::*;

   logic        ACLK   = 1'b0;
   logic        ARESET = 1'b1;
   logic [1:0]  req    = 2'b00;
   logic [1:0]  we     = 2'b00;
   logic [3:0]  addr0  = '0, addr1 = '0;
   logic [31:0] wdata0 = '0, wdata1 = '0;
   logic [1:0]  done;
   logic [31:0] rdata;
   logic [1:0]  resp;
   logic [3:0]  AWADDR, ARADDR;
   logic [2:0]  AWPROT, ARPROT;
   logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        AWREADY = 0, WREADY = 0, BVALID = 0, ARREADY = 0, RVALID = 0;
   logic [1:0]  BRESP = 0, RRESP = 0;
   logic [31:0] RDATA = 0;

   propuestacero_axil_arbiter #(.ADDR_W(4), .DATA_W(32)) dut (
      .ACLK(ACLK), .ARESET(ARESET), .req(req), .we(we),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .done(done), .rdata(rdata), .resp(resp),
      .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
      .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
      .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
      .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
      .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
   );

   always #5 ACLK = ~ACLK;

   typedef struct { logic we; logic [3:0] addr; logic [31:0] wdata; } op_t;
   typedef struct { logic port; logic we; logic [31:0] rdata; logic [1:0] resp; } exp_t;

   op_t         ops0[$], ops1[$];
   exp_t        sb[$];
   logic [31:0] ref_regs[4];
   logic        m_last = 1'b1;
   int          n_checks = 0, n_fail = 0, cyc = 0;
   int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
   bit          err_en = 0, b2b_check = 0;
   int          prev_done1 = -1;

   always @(posedge ACLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // AXI4-Lite slave: four registers, programmable per-channel wait states.
   logic [31:0] s_regs[4];
   bit          s_aw_got = 0, s_w_got = 0, s_ar_got = 0, s_rst = 0;
   logic [3:0]  s_awaddr = 0, s_araddr = 0;
   logic [31:0] s_wdata = 0;
   int          s_aw_wait = 0, s_w_wait = 0, s_ar_wait = 0, s_b_wait = 0, s_r_wait = 0;
   logic        p_awhs = 0, p_whs = 0, p_bhs = 0, p_arhs = 0, p_rhs = 0;
   logic [3:0]  p_awaddr = 0, p_araddr = 0;
   logic [31:0] p_wdata = 0;

   initial begin : slave
      for (int i = 0; i < 4; i++) s_regs[i] = '0;
      forever begin
         @(posedge ACLK);
         s_rst = ARESET;
         #1;
         if (s_rst) begin
            for (int i = 0; i < 4; i++) s_regs[i] = '0;
            s_aw_got = 0; s_w_got = 0; s_ar_got = 0;
            s_aw_wait = 0; s_w_wait = 0; s_ar_wait = 0; s_b_wait = 0; s_r_wait = 0;
            BVALID = 0; RVALID = 0;
         end else begin
            if (p_awhs) begin s_aw_got = 1; s_awaddr = p_awaddr; end
            if (p_whs)  begin s_w_got = 1;  s_wdata = p_wdata; end
            if (p_bhs)  BVALID = 0;
            if (p_arhs) begin s_ar_got = 1; s_araddr = p_araddr; end
            if (p_rhs)  RVALID = 0;
            if (s_aw_got && s_w_got && !BVALID) begin
               if (s_b_wait >= b_delay) begin
                  s_regs[s_awaddr[3:2]] = s_wdata;
                  BVALID = 1; BRESP = c_okay;
                  s_aw_got = 0; s_w_got = 0; s_b_wait = 0;
               end else s_b_wait++;
            end
            if (s_ar_got && !RVALID) begin
               if (s_r_wait >= r_delay) begin
                  RDATA = s_regs[s_araddr[3:2]];
                  RRESP = (err_en && s_araddr == c_reg2) ? c_slverr : c_okay;
                  RVALID = 1; s_ar_got = 0; s_r_wait = 0;
               end else s_r_wait++;
            end
         end
         AWREADY = 0; WREADY = 0; ARREADY = 0;
         if (AWVALID && !s_aw_got) begin
            if (s_aw_wait >= aw_delay) begin AWREADY = 1; s_aw_wait = 0; end else s_aw_wait++;
         end
         if (WVALID && !s_w_got) begin
            if (s_w_wait >= w_delay) begin WREADY = 1; s_w_wait = 0; end else s_w_wait++;
         end
         if (ARVALID && !s_ar_got && !RVALID) begin
            if (s_ar_wait >= ar_delay) begin ARREADY = 1; s_ar_wait = 0; end else s_ar_wait++;
         end
         p_awhs = AWVALID && AWREADY; p_whs = WVALID && WREADY; p_bhs = BVALID && BREADY;
         p_arhs = ARVALID && ARREADY; p_rhs = RVALID && RREADY;
         p_awaddr = AWADDR; p_araddr = ARADDR; p_wdata = WDATA;
      end
   end

   // Monitor: protocol rules every cycle, scoreboard pop on each done pulse.
   logic       q_awv = 0, q_awr = 0, q_wv = 0, q_wr = 0, q_arv = 0, q_arr = 0;
   logic [3:0] q_awaddr = 0, q_araddr = 0;
   logic [31:0] q_wdata = 0;
   int         n_bhs = 0, n_rhs = 0, aw_cyc = 0, w_cyc = 0, last_bhs = 0, last_rhs = 0;

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge ACLK);
         if (ARESET) begin
            n_bhs = 0; n_rhs = 0; aw_cyc = 0; w_cyc = 0;
            q_awv = 0; q_awr = 0; q_wv = 0; q_wr = 0; q_arv = 0; q_arr = 0;
         end else begin
            if (q_awv && !q_awr) begin
               chk("awvalid_hold", 32'(AWVALID), 32'd1);
               chk("awaddr_stable", 32'(AWADDR), 32'(q_awaddr));
            end
            if (q_wv && !q_wr) begin
               chk("wvalid_hold", 32'(WVALID), 32'd1);
               chk("wdata_stable", WDATA, q_wdata);
            end
            if (q_arv && !q_arr) begin
               chk("arvalid_hold", 32'(ARVALID), 32'd1);
               chk("araddr_stable", 32'(ARADDR), 32'(q_araddr));
            end
            if (q_awv && q_awr) chk("awvalid_drop", 32'(AWVALID), 32'd0);
            if (q_wv && q_wr)   chk("wvalid_drop", 32'(WVALID), 32'd0);
            if (q_arv && q_arr) chk("arvalid_drop", 32'(ARVALID), 32'd0);
            if (AWVALID) aw_cyc++;
            if (WVALID)  w_cyc++;
            if (BVALID && BREADY) begin n_bhs++; last_bhs = cyc; end
            if (RVALID && RREADY) begin n_rhs++; last_rhs = cyc; end
            if (done != 2'b00) begin
               if (sb.size() == 0) begin
                  chk("unexpected_done", 32'(done), 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("done_port", 32'(done), e.port ? 32'd2 : 32'd1);
                  chk("rdata", rdata, e.rdata);
                  chk("resp", 32'(resp), 32'(e.resp));
                  if (e.we) begin
                     chk("b_handshakes", 32'(n_bhs), 32'd1);
                     chk("done_after_b", 32'(cyc - last_bhs), 32'd1);
                     chk("awvalid_cycles", 32'(aw_cyc), 32'(aw_delay + 1));
                     chk("wvalid_cycles", 32'(w_cyc), 32'(w_delay + 1));
                  end else begin
                     chk("r_handshakes", 32'(n_rhs), 32'd1);
                     chk("done_after_r", 32'(cyc - last_rhs), 32'd1);
                  end
                  if (e.port) begin
                     if (b2b_check && prev_done1 >= 0)
                        chk("b2b_interval", 32'(cyc - prev_done1), 32'd4);
                     prev_done1 = cyc;
                  end
               end
               n_bhs = 0; n_rhs = 0; aw_cyc = 0; w_cyc = 0;
            end
            q_awv = AWVALID; q_awr = AWREADY; q_wv = WVALID; q_wr = WREADY;
            q_arv = ARVALID; q_arr = ARREADY;
            q_awaddr = AWADDR; q_araddr = ARADDR; q_wdata = WDATA;
         end
      end
   end

   task automatic load_op(input int p, input op_t o);
      we[p] = o.we;
      if (p == 0) begin addr0 = o.addr; wdata0 = o.wdata; end
      else        begin addr1 = o.addr; wdata1 = o.wdata; end
   endtask

   // Predict completion order from the round-robin rule, then drive both queues.
   task automatic run_phase();
      int i0 = 0, i1 = 0, got = 0, k = 0, total, budget;
      int nxt[2];
      bit drop[2];
      logic lst = m_last, g;
      op_t o;
      exp_t e;
      total = ops0.size() + ops1.size();
      while (i0 < ops0.size() || i1 < ops1.size()) begin
         if (i0 < ops0.size() && i1 < ops1.size()) g = ~lst;
         else g = (i1 < ops1.size());
         if (g) begin o = ops1[i1]; i1++; end else begin o = ops0[i0]; i0++; end
         e.port = g; e.we = o.we;
         if (o.we) begin
            ref_regs[o.addr[3:2]] = o.wdata; e.rdata = '0; e.resp = c_okay;
         end else begin
            e.rdata = ref_regs[o.addr[3:2]];
            e.resp  = (err_en && o.addr == c_reg2) ? c_slverr : c_okay;
         end
         sb.push_back(e);
         lst = g;
      end
      m_last = lst;
      budget = 40 * total + 20;
      nxt[0] = 0; nxt[1] = 0; drop[0] = 0; drop[1] = 0;
      if (ops0.size() > 0) begin load_op(0, ops0[0]); nxt[0] = 1; req[0] = 1; end
      if (ops1.size() > 0) begin load_op(1, ops1[0]); nxt[1] = 1; req[1] = 1; end
      while (got < total && k < budget) begin
         @(posedge ACLK); #2; k++;
         for (int p = 0; p < 2; p++) begin
            if (drop[p]) begin
               drop[p] = 0;
               if (p == 0 && nxt[0] < ops0.size()) begin load_op(0, ops0[nxt[0]]); nxt[0]++; end
               else if (p == 1 && nxt[1] < ops1.size()) begin load_op(1, ops1[nxt[1]]); nxt[1]++; end
               else req[p] = 0;
            end
            if (done[p]) begin drop[p] = 1; got++; end
         end
      end
      @(posedge ACLK); #2;
      req = 2'b00;
      if (got < total) begin
         chk("phase_timeout", 32'(got), 32'(total));
         sb.delete();
      end
      ops0.delete(); ops1.delete();
   endtask

   function automatic op_t mk(input logic w, input logic [3:0] a, input logic [31:0] d);
      op_t o;
      o.we = w; o.addr = a; o.wdata = d;
      return o;
   endfunction

   initial begin : main
      int k;
      for (int i = 0; i < 4; i++) ref_regs[i] = '0;
      repeat (3) @(posedge ACLK);
      #2;
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_resp", 32'(resp), 32'd0);
      chk("rst_valids", 32'({AWVALID, WVALID, ARVALID}), 32'd0);
      chk("rst_readies", 32'({BREADY, RREADY}), 32'd0);
      chk("prot_strb", 32'({AWPROT, ARPROT, WSTRB}), 32'h00F);
      ARESET = 0;

      // Requester 0: write 1..4 then read back.
      ops0.push_back(mk(1, c_reg0, 32'd1)); ops0.push_back(mk(1, c_reg1, 32'd2));
      ops0.push_back(mk(1, c_reg2, 32'd3)); ops0.push_back(mk(1, c_reg3, 32'd4));
      ops0.push_back(mk(0, c_reg0, 0)); ops0.push_back(mk(0, c_reg1, 0));
      ops0.push_back(mk(0, c_reg2, 0)); ops0.push_back(mk(0, c_reg3, 0));
      run_phase();

      // Reset while waiting for BVALID.
      b_delay = 3;
      load_op(0, mk(1, c_reg0, 32'h1234_5678)); req[0] = 1;
      k = 0;
      while (!BREADY && k < 20) begin @(posedge ACLK); #2; k++; end
      chk("reach_wr_b", 32'(BREADY), 32'd1);
      ARESET = 1; req = 2'b00;
      @(posedge ACLK); #2;
      chk("abort_valids", 32'({AWVALID, WVALID, ARVALID, BREADY, RREADY}), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      ARESET = 0; b_delay = 0;
      m_last = 1'b1;
      for (int i = 0; i < 4; i++) ref_regs[i] = '0;

      // Both pending from reset: grants 0,1,0,1.
      ops0.push_back(mk(1, c_reg1, 32'hA5A5_A5A5)); ops0.push_back(mk(1, c_reg0, 32'h0F0F_0F0F));
      ops1.push_back(mk(0, c_reg1, 0)); ops1.push_back(mk(0, c_reg1, 0));
      run_phase();

      // Slow AWREADY, immediate WREADY.
      aw_delay = 2;
      ops0.push_back(mk(1, c_reg2, 32'h0000_0055));
      run_phase();
      aw_delay = 0;

      // Slave error on register 2.
      err_en = 1;
      ops0.push_back(mk(0, c_reg2, 0));
      run_phase();
      err_en = 0;

      // Back-to-back reads from requester 1 against a zero-wait slave.
      b2b_check = 1; prev_done1 = -1;
      ops1.push_back(mk(0, c_reg0, 0)); ops1.push_back(mk(0, c_reg1, 0));
      ops1.push_back(mk(0, c_reg2, 0)); ops1.push_back(mk(0, c_reg3, 0));
      run_phase();
      b2b_check = 0;

      for (int ph = 0; ph < 25; ph++) begin
         int n0, n1;
         n0 = $urandom_range(0, 3); n1 = $urandom_range(0, 3);
         if (n0 + n1 == 0) n0 = 1;
         aw_delay = $urandom_range(0, 2); w_delay = $urandom_range(0, 2);
         b_delay  = $urandom_range(0, 2); ar_delay = $urandom_range(0, 2);
         r_delay  = $urandom_range(0, 2); err_en = ($urandom_range(0, 1) == 1);
         for (int i = 0; i < n0; i++)
            ops0.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3) * 4), $urandom));
         for (int i = 0; i < n1; i++)
            ops1.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3) * 4), $urandom));
         run_phase();
      end

      repeat (5) @(posedge ACLK);
      #2;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
